// File: rtl/disp_pkg.sv
// disp_pkg: shared types, defaults and helpers for the seven-segment display path.
package disp_pkg;

  typedef enum logic [0:0] {
    SCAN_ON   = 1'b0,
    SCAN_DEAD = 1'b1
  } scan_state_t;

  localparam int DEF_NUM_DIGITS  = 4;
  localparam int DEF_TICK_DIV    = 100000;
  localparam int DEF_DEAD_CYCLES = 16;

  // Widest digit count the one-hot helper can express.
  localparam int MAX_DIGITS = 32;

  // Active-low one-hot: bit idx is 0, every other bit is 1.
  function automatic logic [MAX_DIGITS-1:0] onehot_low(input int unsigned idx);
    logic [MAX_DIGITS-1:0] v;
    v = '1;
    v[idx[4:0]] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// tick_divider: prescaler counting 0..DIV-1 while enabled, with synchronous
// restart. tick is high in the cycle where the count sits at DIV-1 and en=1,
// so the wrap and any consumer update land on the same edge.
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign tick = en && (count == LAST);

  // Count while enabled, wrap at terminal count, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (en) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/anode_scanner.sv
// anode_scanner: free-running common-anode digit multiplexer with per-digit
// blanking, scan enable and a slot-start strobe for the segment-data mux.
// Optional macro ANODE_SCAN_DEADTIME_EN inserts DEAD_CYCLES all-off cycles
// after every slot to suppress ghosting between digits.
module anode_scanner
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES,
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [SW-1:0]         digit_sel,
  output logic                  slot_start
);

  localparam logic [SW-1:0]         LAST_SEL  = SW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_RST = {{(NUM_DIGITS-1){1'b1}}, 1'b0};
  localparam logic [NUM_DIGITS-1:0] ALL_OFF   = '1;

  if (NUM_DIGITS < 2 || NUM_DIGITS > MAX_DIGITS || TICK_DIV < 2 || DEAD_CYCLES < 1) begin : g_bad_params
    $error("anode_scanner: illegal parameter combination");
  end

  logic                  on_en;
  logic                  on_tick;
  logic [SW-1:0]         next_sel;
  logic [NUM_DIGITS-1:0] drive_cur;
  logic [NUM_DIGITS-1:0] drive_next;

  assign next_sel = (digit_sel == LAST_SEL) ? '0 : digit_sel + 1'b1;

  // A blanked digit or a disabled scan forces its anode high; only the
  // selected bit can be low in the one-hot, so OR-ing the mask is enough.
  assign drive_cur  = NUM_DIGITS'(onehot_low(32'(digit_sel))) | blank_mask | {NUM_DIGITS{~en}};
  assign drive_next = NUM_DIGITS'(onehot_low(32'(next_sel)))  | blank_mask | {NUM_DIGITS{~en}};

  tick_divider #(.DIV(TICK_DIV)) u_on_div (
    .clk     (clk),
    .rst     (rst),
    .en      (on_en),
    .restart (1'b0),
    .tick    (on_tick)
  );

`ifdef ANODE_SCAN_DEADTIME_EN
  scan_state_t state;
  logic        dead_tick;

  assign on_en = en && (state == SCAN_ON);

  tick_divider #(.DIV(DEAD_CYCLES)) u_dead_div (
    .clk     (clk),
    .rst     (rst),
    .en      (en && (state == SCAN_DEAD)),
    .restart (1'b0),
    .tick    (dead_tick)
  );

  // Slot sequencer: ON slot, then an all-off gap before the next digit lights.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SCAN_ON;
      digit_sel  <= '0;
      slot_start <= 1'b0;
      anode      <= ANODE_RST;
    end else begin
      slot_start <= on_tick;
      case (state)
        SCAN_ON: begin
          if (on_tick) begin
            digit_sel <= next_sel;
            state     <= SCAN_DEAD;
            anode     <= ALL_OFF;
          end else begin
            anode <= drive_cur;
          end
        end
        default: begin
          if (dead_tick) begin
            state <= SCAN_ON;
            anode <= drive_cur;
          end else begin
            anode <= ALL_OFF;
          end
        end
      endcase
    end
  end
`else
  assign on_en = en;

  // Slot sequencer: advance the digit and refresh the anodes on every wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_sel  <= '0;
      slot_start <= 1'b0;
      anode      <= ANODE_RST;
    end else begin
      slot_start <= on_tick;
      if (on_tick) begin
        digit_sel <= next_sel;
        anode     <= drive_next;
      end else begin
        anode <= drive_cur;
      end
    end
  end
`endif

endmodule

// File: tb/tb_anode_scanner.sv
// Directed bench for anode_scanner: scan order, blanking, enable hold,
// asynchronous reset, a 6-digit wrap and (with the macro) the dead gap.
module tb_anode_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [3:0] mask = 4'b0000;
  logic [3:0] anode;
  logic [1:0] sel;
  logic       ss;

  logic       rst_b = 1'b1;
  logic [5:0] anode_b;
  logic [2:0] sel_b;
  logic       ss_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  anode_scanner #(.NUM_DIGITS(4), .TICK_DIV(4), .DEAD_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .blank_mask (mask),
    .anode      (anode),
    .digit_sel  (sel),
    .slot_start (ss)
  );

  anode_scanner #(.NUM_DIGITS(6), .TICK_DIV(2), .DEAD_CYCLES(2)) dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .en         (1'b1),
    .blank_mask (6'b000000),
    .anode      (anode_b),
    .digit_sel  (sel_b),
    .slot_start (ss_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk3(input string tag, input logic [3:0] a, input logic [1:0] s, input logic p);
    chk({tag, ".anode"}, 32'(anode), 32'(a));
    chk({tag, ".sel"}, 32'(sel), 32'(s));
    chk({tag, ".ss"}, 32'(ss), 32'(p));
  endtask

  initial begin
    logic [1:0] es;
    logic [3:0] ea;
    step();
    step();
    rst = 1'b0;
    chk3("reset", 4'b1110, 2'd0, 1'b0);

`ifdef ANODE_SCAN_DEADTIME_EN
    // Digit 0 for 4 cycles, 2 dark cycles showing digit 1, digit 1 for 4, gap again.
    for (int k = 1; k <= 12; k++) begin
      step();
      case (k)
        1, 2, 3:      chk3("dead", 4'b1110, 2'd0, 1'b0);
        4:            chk3("dead", 4'b1111, 2'd1, 1'b1);
        5:            chk3("dead", 4'b1111, 2'd1, 1'b0);
        6, 7, 8, 9:   chk3("dead", 4'b1101, 2'd1, 1'b0);
        10:           chk3("dead", 4'b1111, 2'd2, 1'b1);
        11:           chk3("dead", 4'b1111, 2'd2, 1'b0);
        default:      chk3("dead", 4'b1011, 2'd2, 1'b0);
      endcase
    end
`else
    // Plain rotation: digit changes every 4 edges.
    for (int k = 1; k <= 16; k++) begin
      step();
      es = 2'((k / 4) % 4);
      ea = 4'b1111;
      ea[es] = 1'b0;
      chk3("scan", ea, es, (k % 4) == 0);
    end

    // Blank digit 1: dark for its slot, timing unchanged.
    mask = 4'b0010;
    for (int k = 1; k <= 8; k++) begin
      step();
      es = 2'(k / 4);
      ea = 4'b1111;
      if (es != 2'd1) ea[es] = 1'b0;
      chk3("blank", ea, es, (k % 4) == 0);
    end
    mask = 4'b0000;

    // Drop enable at count 2 of digit 2 for 5 cycles.
    step();
    step();
    chk3("pre_en", 4'b1011, 2'd2, 1'b0);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk3("en_off", 4'b1111, 2'd2, 1'b0);
    end
    en = 1'b1;
    step();
    chk3("en_back1", 4'b1011, 2'd2, 1'b0);
    step();
    chk3("en_back2", 4'b0111, 2'd3, 1'b1);

    // Asynchronous reset in the middle of digit 3.
    step();
    step();
    chk3("pre_rst", 4'b0111, 2'd3, 1'b0);
    #1 rst = 1'b1;
    #1 chk3("async_rst", 4'b1110, 2'd0, 1'b0);
    #1 rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k < 4) chk3("post_rst", 4'b1110, 2'd0, 1'b0);
      else       chk3("post_rst", 4'b1101, 2'd1, 1'b1);
    end

    // Six digits, two cycles each: check the 5 -> 0 wrap.
    rst_b = 1'b0;
    chk("b_reset.anode", 32'(anode_b), 32'h3E);
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 10) begin
        chk("b_d5.anode", 32'(anode_b), 32'h1F);
        chk("b_d5.sel", 32'(sel_b), 32'd5);
        chk("b_d5.ss", 32'(ss_b), 32'd1);
      end
      if (k == 12) begin
        chk("b_wrap.anode", 32'(anode_b), 32'h3E);
        chk("b_wrap.sel", 32'(sel_b), 32'd0);
        chk("b_wrap.ss", 32'(ss_b), 32'd1);
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/anode_scanner.md
# anode_scanner

Parametrised, free-running multiplexer for common-anode seven-segment displays. It divides the system clock into per-digit slots and rotates a one-hot, active-low anode select across `NUM_DIGITS` digits. It adds per-digit blanking, a scan enable and a slot-start strobe for the upstream segment-data mux. It sits between the time/alarm display datapath and the board anode pins.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned; must be ≥ 2.
- `TICK_DIV`, 100000: clock cycles each digit is driven; must be ≥ 2.
- `DEAD_CYCLES`, 16: all-off cycles between digits; must be ≥ 1; used only with `ANODE_SCAN_DEADTIME_EN`.
- `clk  in  1`: single system clock; all state updates on the rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `en  in  1`: scan enable.
- `blank_mask  in  NUM_DIGITS`: bit i = 1 forces digit i dark during its slot.
- `anode  out  NUM_DIGITS`: registered, active-low, at most one bit low.
- `digit_sel  out  max(1,$clog2(NUM_DIGITS))`: index of the current slot.
- `slot_start  out  1`: one-cycle pulse marking a new slot.

## Operation
- Reset values: `anode` = all ones except bit 0 low (1110 for N=4); `digit_sel` = 0; `slot_start` = 0; divider count = 0; state SCAN_ON.
- Divider counts 0..TICK_DIV-1 while `en`=1. It holds its value while `en`=0.
- `en`=1 with count = TICK_DIV-1: count returns to 0, `digit_sel` advances by 1 modulo NUM_DIGITS (NUM_DIGITS-1 → 0), and `slot_start` is 1 for that cycle.
- `anode[i]` is 0 only when all of these hold: `i` = `digit_sel`, `en` = 1, `blank_mask[i]` = 0, state = SCAN_ON. Otherwise `anode[i]` is 1.
- `en`=0: `digit_sel` holds. Anodes are all 1 from the next edge. `slot_start` = 0. When `en` returns to 1, scanning resumes from the held count.
- Blanking does not alter the scan timing; `digit_sel` and `slot_start` sequence normally while a digit is blanked.
- `rst` mid-slot returns all state to the reset values immediately, without waiting for a clock edge.

## Timing
- `anode` reacts to `en` and `blank_mask` with 1-cycle latency (registered).
- Without the macro, slot period = TICK_DIV cycles. After reset release, the first advance occurs at the TICK_DIV-th rising edge.
- `digit_sel`, `slot_start` and the `anode` move all update on the same edge.
- A `blank_mask` change mid-slot takes effect at the next edge.

## Configuration
- Macro: `ANODE_SCAN_DEADTIME_EN`.
- Defined: two states, SCAN_ON and SCAN_DEAD.
  - When the divider wraps in SCAN_ON, `digit_sel` advances, `slot_start` pulses and the block enters SCAN_DEAD.
  - In SCAN_DEAD, all anodes are 1 for DEAD_CYCLES cycles, then the block returns to SCAN_ON with count 0.
  - Slot period = TICK_DIV + DEAD_CYCLES cycles.
  - `en`=0 freezes the dead counter as well.
- Undefined: SCAN_ON only; the DEAD_CYCLES parameter is ignored; no dead-time logic is generated.

## Structure
- Shared package `disp_pkg`:
  - typedef `scan_state_t` {SCAN_ON, SCAN_DEAD};
  - default constants for NUM_DIGITS, TICK_DIV and DEAD_CYCLES;
  - function `onehot_low(idx)` returning the active-low one-hot vector.
- Sub-module `tick_divider`: parametrised prescaler with enable and synchronous restart, producing a 1-cycle `tick` at terminal count. It is reused for both the ON count and the dead count.

## Test plan
1. N=4, TICK_DIV=4, `en`=1, mask=0 → `anode` is 1110 for 4 cycles, then 1101, 1011, 0111, 1110; `digit_sel` goes 0,1,2,3,0; `slot_start` pulses every 4 cycles.
2. Same setup, mask=0010 → `anode`=1111 throughout slot 1; `digit_sel`=1 during slot 1 and `slot_start` still pulses; slot 2 starts on time with 1011.
3. `en` dropped at count 2 of digit 2 for 5 cycles → `anode`=1111 from the next edge and `digit_sel` holds 2. After `en` returns, digit 2 stays active 2 more cycles before 0111.
4. `rst` pulsed asynchronously mid digit 3 → `anode`=1110, `digit_sel`=0 and `slot_start`=0 without a clock edge. The first advance occurs at the 4th edge after release.
5. N=6, TICK_DIV=2 → `digit_sel` wraps 5→0 and `anode` goes 011111 → 111110; `digit_sel` is 3 bits wide.
6. `ANODE_SCAN_DEADTIME_EN`, N=4, TICK_DIV=4, DEAD_CYCLES=2 → digit 0 on for 4 cycles, then 1111 for 2 cycles with `digit_sel`=1, then 1101 for 4 cycles; slot period is 6 cycles.
